// File: rtl/inst_fetch_buf_pkg.sv
// rtl/inst_fetch_buf_pkg.sv - shared widths and fetch-enable encodings for the fetch front end
package inst_fetch_buf_pkg;

    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;

    localparam logic FETCH_ENABLE  = 1'b1;
    localparam logic FETCH_DISABLE = 1'b0;

endpackage

// File: rtl/inst_fetch_buf_fetch_fifo.sv
// rtl/inst_fetch_buf_fetch_fifo.sv - prefetch FIFO holding {pc, inst} pairs, synchronous clear
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - sequential PC generator, ROM req/ack fetch and prefetch buffer to ID
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_BUS_W,
    parameter int                INST_W   = INST_BUS_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [ADDR_W-1:0]      rom_addr_o,
    input  logic                   rom_ack_i,
    input  logic [INST_W-1:0]      rom_data_i,
    output logic                   id_valid_o,
    output logic [ADDR_W-1:0]      id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    input  logic                   id_ready_i,
    input  logic                   flush_i,
    input  logic [ADDR_W-1:0]      new_pc_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int WIDTH = ADDR_W + INST_W;

    logic [ADDR_W-1:0] pc;
    logic              en_q;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [WIDTH-1:0]  fifo_dout;

    // Request depends only on registered state, never on ID backpressure or flush.
    assign rom_ce_o   = (en_q == FETCH_ENABLE) && !full;
    assign rom_addr_o = pc;
    assign push       = rom_ce_o && rom_ack_i && !flush_i;
    assign pop        = !empty && id_ready_i && !flush_i;
    assign id_valid_o = !empty;
    assign id_pc_o    = fifo_dout[WIDTH-1 -: ADDR_W];
    assign id_inst_o  = fifo_dout[INST_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= FETCH_DISABLE;
            pc   <= RESET_PC;
        end else begin
            en_q <= FETCH_ENABLE;
            if (flush_i) begin
                pc <= new_pc_i;
            end else if (push) begin
                pc <= pc + ADDR_W'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (flush_i),
        .din   ({pc, rom_data_i}),
        .dout  (fifo_dout),
        .count (count_o),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb/tb_inst_fetch_buf.sv - directed self-checking bench for inst_fetch_buf
module tb_inst_fetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic        rom_ack_i;
    logic [31:0] rom_data_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM contents: each word is its address XORed with a fixed tag.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign rom_data_i = rom_word(rom_addr_o);

    inst_fetch_buf dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_o   (rom_ce_o),
        .rom_addr_o (rom_addr_o),
        .rom_ack_i  (rom_ack_i),
        .rom_data_i (rom_data_i),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_ready_i (id_ready_i),
        .flush_i    (flush_i),
        .new_pc_i   (new_pc_i),
        .count_o    (count_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        rom_ack_i  = 1'b1;
        id_ready_i = 1'b1;
        flush_i    = 1'b0;
        new_pc_i   = '0;

        #2;
        check("rst_ce", 64'(rom_ce_o), 64'd0);
        check("rst_valid", 64'(id_valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_addr", 64'(rom_addr_o), 64'h0);

        // Streaming fetch with ack and ready always high.
        tick();
        rst = 1'b1;
        tick();
        check("s_first_ce", 64'(rom_ce_o), 64'd1);
        check("s_first_addr", 64'(rom_addr_o), 64'h0);
        check("s_first_valid", 64'(id_valid_o), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("s_addr", 64'(rom_addr_o), 64'(32'(4 * i)));
            check("s_valid", 64'(id_valid_o), 64'd1);
            check("s_pc", 64'(id_pc_o), 64'(32'(4 * (i - 1))));
            check("s_inst", 64'(id_inst_o), 64'(rom_word(32'(4 * (i - 1)))));
            check("s_count", 64'(count_o), 64'd1);
        end

        // Fill to full under stall, then release a single pop.
        flush_i = 1'b1; new_pc_i = 32'h0; id_ready_i = 1'b0;
        tick();
        flush_i = 1'b0;
        check("f_count0", 64'(count_o), 64'd0);
        check("f_addr0", 64'(rom_addr_o), 64'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("f_count", 64'(count_o), 64'(i));
        end
        check("f_full_ce", 64'(rom_ce_o), 64'd0);
        check("f_full_addr", 64'(rom_addr_o), 64'h10);
        tick();
        check("f_hold_count", 64'(count_o), 64'd4);
        check("f_hold_addr", 64'(rom_addr_o), 64'h10);
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        check("f_pop_count", 64'(count_o), 64'd3);
        check("f_pop_ce", 64'(rom_ce_o), 64'd1);
        check("f_pop_head", 64'(id_pc_o), 64'h4);
        tick();
        check("f_refill_count", 64'(count_o), 64'd4);
        check("f_refill_addr", 64'(rom_addr_o), 64'h14);

        // Un-acked request holds its address.
        flush_i = 1'b1; new_pc_i = 32'h0; id_ready_i = 1'b1; rom_ack_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        tick();
        check("h_addr8", 64'(rom_addr_o), 64'h8);
        rom_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("h_stable_addr", 64'(rom_addr_o), 64'h8);
            check("h_stable_ce", 64'(rom_ce_o), 64'd1);
        end
        rom_ack_i = 1'b1;
        tick();
        check("h_pc_after", 64'(rom_addr_o), 64'hC);
        check("h_valid", 64'(id_valid_o), 64'd1);
        check("h_head_pc", 64'(id_pc_o), 64'h8);
        check("h_head_inst", 64'(id_inst_o), 64'(rom_word(32'h8)));
        check("h_count", 64'(count_o), 64'd1);

        // Flush with ack and ready in the same cycle, count 3.
        id_ready_i = 1'b0;
        tick();
        tick();
        check("x_count3", 64'(count_o), 64'd3);
        flush_i = 1'b1; new_pc_i = 32'h400; id_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("x_count", 64'(count_o), 64'd0);
        check("x_valid", 64'(id_valid_o), 64'd0);
        check("x_addr", 64'(rom_addr_o), 64'h400);
        tick();
        check("x_head_pc", 64'(id_pc_o), 64'h400);
        check("x_head_inst", 64'(id_inst_o), 64'(rom_word(32'h400)));
        check("x_count1", 64'(count_o), 64'd1);

        // PC wraps at the top of the address space.
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
        tick();
        flush_i = 1'b0;
        check("w_addr_top", 64'(rom_addr_o), 64'hFFFF_FFFC);
        tick();
        check("w_addr_wrap", 64'(rom_addr_o), 64'h0);
        check("w_head_pc", 64'(id_pc_o), 64'hFFFF_FFFC);

        // Back-to-back flushes: last target wins.
        flush_i = 1'b1; new_pc_i = 32'h100;
        tick();
        new_pc_i = 32'h200;
        tick();
        flush_i = 1'b0;
        check("b_addr", 64'(rom_addr_o), 64'h200);
        check("b_count", 64'(count_o), 64'd0);

        // Asynchronous reset mid-stream with two entries buffered.
        id_ready_i = 1'b0;
        tick();
        tick();
        check("r_count2", 64'(count_o), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        check("r_async_ce", 64'(rom_ce_o), 64'd0);
        check("r_async_valid", 64'(id_valid_o), 64'd0);
        check("r_async_count", 64'(count_o), 64'd0);
        check("r_async_addr", 64'(rom_addr_o), 64'h0);
        tick();
        rst = 1'b1;
        tick();
        check("r_restart_ce", 64'(rom_ce_o), 64'd1);
        check("r_restart_addr", 64'(rom_addr_o), 64'h0);
        tick();
        check("r_restart_pc", 64'(id_pc_o), 64'h0);
        check("r_restart_next", 64'(rom_addr_o), 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
